// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file.
// Holds the clear-sequencer state encoding and default geometry.
package reg_file_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_p_clr_seq.sv
// Clear sequencer: walks every address once, one word per cycle.
// busy is the registered CLEAR state; clr is ignored while busy.
module clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_adr,
  output logic              clr_we
);

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  // state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state: start on clr, leave after the last address
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_CLEAR);
  assign clr_we  = busy;
  assign clr_adr = cnt;

endmodule

// File: rtl/reg_file_p.sv
// 1W/2R register file with bypass, valid bits and hardware clear.
// Define REG_FILE_P_R0_ZERO_EN to hardwire word 0 to zero/valid.
module reg_file_p
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] W_Adr,
  input  logic [DATA_W-1:0] W,
  input  logic [ADDR_W-1:0] R_Adr,
  input  logic [ADDR_W-1:0] S_Adr,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S,
  output logic              R_vld,
  output logic              S_vld,
  input  logic              clr,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef REG_FILE_P_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] clr_adr;
  logic              clr_we;
  logic              wr_ok;
  logic              r_r0;
  logic              s_r0;
  logic              r_byp;
  logic              s_byp;

  clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .busy   (busy),
    .clr_adr(clr_adr),
    .clr_we (clr_we)
  );

  assign wr_drop = we & busy;
  assign wr_ok   = we & ~busy
                 & ~(R0_ZERO & (W_Adr == '0));
  assign r_r0    = R0_ZERO & (R_Adr == '0);
  assign s_r0    = R0_ZERO & (S_Adr == '0);
  assign r_byp   = BYPASS & wr_ok
                 & (W_Adr == R_Adr);
  assign s_byp   = BYPASS & wr_ok
                 & (W_Adr == S_Adr);

  // array: clear sequencer has priority, writes only in idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld <= '0;
    end else if (clr_we) begin
      mem[clr_adr] <= '0;
      vld[clr_adr] <= 1'b0;
    end else if (wr_ok) begin
      mem[W_Adr] <= W;
      vld[W_Adr] <= 1'b1;
    end
  end

  // read port R: hardwired zero, bypass, or stored word
  always_comb begin
    R     = mem[R_Adr];
    R_vld = vld[R_Adr];
    unique case (1'b1)
      r_r0: begin
        R     = '0;
        R_vld = 1'b1;
      end
      r_byp: begin
        R     = W;
        R_vld = 1'b1;
      end
      default: ;
    endcase
  end

  // read port S: same rules, independent of R
  always_comb begin
    S     = mem[S_Adr];
    S_vld = vld[S_Adr];
    unique case (1'b1)
      s_r0: begin
        S     = '0;
        S_vld = 1'b1;
      end
      s_byp: begin
        S     = W;
        S_vld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_file_p.sv
// Bench for reg_file_p: BYPASS=1 and BYPASS=0 copies side by side,
// checked every cycle against an array model plus directed pins.
module tb_reg_file_p;

`ifdef REG_FILE_P_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  W_Adr;
  logic [15:0] W;
  logic [2:0]  R_Adr;
  logic [2:0]  S_Adr;
  logic        clr;

  logic [15:0] r1, s1, r0, s0;
  logic        r1_v, s1_v, r0_v, s0_v;
  logic        busy1, busy0, drop1, drop0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_mem [8];
  bit          m_vld [8];
  bit          m_busy;
  int          cyc;
  int          clr_at;

  reg_file_p #(
    .DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .we(we),
    .W_Adr(W_Adr), .W(W),
    .R_Adr(R_Adr), .S_Adr(S_Adr),
    .R(r1), .S(s1), .R_vld(r1_v), .S_vld(s1_v),
    .clr(clr), .busy(busy1), .wr_drop(drop1)
  );

  reg_file_p #(
    .DATA_W(16), .ADDR_W(3), .BYPASS(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .we(we),
    .W_Adr(W_Adr), .W(W),
    .R_Adr(R_Adr), .S_Adr(S_Adr),
    .R(r0), .S(s0), .R_vld(r0_v), .S_vld(s0_v),
    .clr(clr), .busy(busy0), .wr_drop(drop0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  // model: clear of word k lands k+1 edges after the clr edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i] = 16'h0;
        m_vld[i] = 1'b0;
      end
      m_busy = 1'b0;
    end else begin
      cyc++;
      if (m_busy) begin
        m_mem[cyc - clr_at - 1] = 16'h0;
        m_vld[cyc - clr_at - 1] = 1'b0;
        if (cyc - clr_at == 8) m_busy = 1'b0;
      end else begin
        if (we && !(R0 && W_Adr == 3'd0)) begin
          m_mem[W_Adr] = W;
          m_vld[W_Adr] = 1'b1;
        end
        if (clr) begin
          m_busy = 1'b1;
          clr_at = cyc;
        end
      end
    end
  end

  function automatic logic [16:0] exp_rd(
    input logic [2:0] a, input bit byp);
    if (R0 && a == 3'd0) return {1'b1, 16'h0};
    if (byp && we && !m_busy && W_Adr == a)
      return {1'b1, W};
    return {m_vld[a], m_mem[a]};
  endfunction

  // per-cycle compare of both copies against the model
  always @(negedge clk) begin
    chk("r_byp1", {r1_v, r1}, exp_rd(R_Adr, 1'b1));
    chk("s_byp1", {s1_v, s1}, exp_rd(S_Adr, 1'b1));
    chk("r_byp0", {r0_v, r0}, exp_rd(R_Adr, 1'b0));
    chk("s_byp0", {s0_v, s0}, exp_rd(S_Adr, 1'b0));
    chk("busy1", busy1, m_busy);
    chk("busy0", busy0, m_busy);
    chk("drop1", drop1, we & m_busy);
    chk("drop0", drop0, we & m_busy);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] a5(input int a);
    return (R0 && a == 0) ? 16'h0 : 16'hA5A5;
  endfunction

  initial begin
    int bc;
    int ra;
    cyc    = 0;
    clr_at = 0;
    reset  = 1'b0;
    we     = 1'b0;
    W_Adr  = 3'd0;
    W      = 16'h0;
    R_Adr  = 3'd0;
    S_Adr  = 3'd0;
    clr    = 1'b0;
    step();
    step();
    reset = 1'b1;

    for (int a = 0; a < 8; a++) begin
      R_Adr = 3'(a);
      S_Adr = 3'(7 - a);
      step();
      #2;
      chk("rst_r", r1, 16'h0);
      chk("rst_rv", r1_v, R0 && a == 0);
      chk("rst_s", s1, 16'h0);
      chk("rst_busy", busy1, 1'b0);
    end

    we = 1'b1; W_Adr = 3'd5; W = 16'hBEEF;
    step();
    we = 1'b0; R_Adr = 3'd5; S_Adr = 3'd4;
    #2;
    chk("wr_r", r1, 16'hBEEF);
    chk("wr_rv", r1_v, 1'b1);
    chk("wr_s", s1, 16'h0);
    chk("wr_sv", s1_v, 1'b0);

    step();
    we = 1'b1; W_Adr = 3'd3; W = 16'h1234;
    R_Adr = 3'd3; S_Adr = 3'd3;
    #2;
    chk("byp_r1", r1, 16'h1234);
    chk("byp_s1", s1, 16'h1234);
    chk("byp_r0", r0, 16'h0000);
    chk("byp_r0v", r0_v, 1'b0);

    step();
    we = 1'b1; W_Adr = 3'd0; W = 16'hFFFF;
    R_Adr = 3'd0;
    #2;
    chk("r0_drop", drop1, 1'b0);
    step();
    we = 1'b0;
    #2;
    chk("r0_rd", r1, R0 ? 16'h0 : 16'hFFFF);
    chk("r0_rv", r1_v, 1'b1);

    for (int a = 0; a < 8; a++) begin
      we = 1'b1; W_Adr = 3'(a); W = 16'hA5A5;
      step();
    end
    we  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    bc  = 0;
    for (int c = 1; c <= 12; c++) begin
      ra    = (c - 2) & 7;
      R_Adr = 3'(ra);
      S_Adr = (c <= 8) ? 3'(c - 1) : 3'd1;
      we    = (c <= 8);
      W_Adr = 3'(ra);
      W     = 16'h1111;
      #2;
      if (busy1) bc++;
      chk("clr_r", r1, (c == 1) ? a5(7) : 16'h0);
      chk("clr_rv", r1_v,
          (R0 && ra == 0) ? 1'b1 : (c == 1));
      if (c <= 8) begin
        chk("clr_s", s1, a5(c - 1));
        chk("clr_drop", drop1, 1'b1);
      end
      step();
    end
    we = 1'b0;
    chk("clr_busy_len", bc, 8);
    for (int a = 0; a < 8; a++) begin
      R_Adr = 3'(a);
      #1;
      chk("clr_after", {r1_v, r1},
          {R0 && a == 0, 16'h0});
    end

    we = 1'b1; W_Adr = 3'd6; W = 16'h7777;
    step();
    we  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    chk("mid_busy", busy1, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_busy1", busy1, 1'b0);
    chk("mid_busy0", busy0, 1'b0);
    R_Adr = 3'd6;
    #1;
    chk("mid_w6", {r1_v, r1}, 17'h0);
    step();
    reset = 1'b1;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    bc  = 0;
    for (int c = 0; c < 11; c++) begin
      #2;
      if (busy1) bc++;
      step();
    end
    chk("rerun_len", bc, 8);

    for (int i = 0; i < 2000; i++) begin
      we    = $urandom_range(0, 1);
      W_Adr = 3'($urandom_range(0, 7));
      W     = 16'($urandom);
      R_Adr = ($urandom_range(0, 3) == 0) ? W_Adr
            : 3'($urandom_range(0, 7));
      S_Adr = ($urandom_range(0, 3) == 0) ? W_Adr
            : 3'($urandom_range(0, 7));
      clr   = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_p.md
Name: reg_file_p

Overview:
- Parametrised successor to the 8x16 register file of the integer data path.
- Provides one synchronous write port and two combinational read ports (R, S) over 2^ADDR_W words of DATA_W bits.
- Adds write-to-read bypass, per-word valid bits and a hardware clear sequencer that zeroes the array one word per cycle.
- Sits between the ALU result bus (W) and the ALU operand inputs (R, S) of the data path.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 3, address width; depth = 2^ADDR_W words.
- BYPASS, 1, 1 = same-cycle write data forwarded to the matching read port; 0 = read returns the stored word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- W_Adr  in  ADDR_W  write address.
- W  in  DATA_W  write data.
- R_Adr  in  ADDR_W  read address, port R.
- S_Adr  in  ADDR_W  read address, port S.
- R  out  DATA_W  read data, port R.
- S  out  DATA_W  read data, port S.
- R_vld  out  1  valid bit of the word at R_Adr.
- S_vld  out  1  valid bit of the word at S_Adr.
- clr  in  1  clear request; sampled only in IDLE.
- busy  out  1  high while the clear sequence runs.
- wr_drop  out  1  combinational; equals we & busy.

Behaviour:
- Reset (reset low, async):
  - all words = 0, all valid bits = 0.
  - FSM = IDLE, clear counter = 0, busy = 0.
  - Outputs follow the combinational read of the cleared array.
  - Reset asserted mid-clear aborts the sequence immediately.
- Write:
  - In IDLE with we=1, mem[W_Adr] <= W and vld[W_Adr] <= 1 at the rising edge.
  - Write latency is 1 cycle; the stored value is visible at R/S the following cycle.
- Read:
  - Combinational, 0 latency: R = mem[R_Adr], R_vld = vld[R_Adr]; S likewise.
  - Both ports may address the same word.
- Bypass (BYPASS=1):
  - If we & ~busy & (W_Adr==R_Adr), then R = W and R_vld = 1.
  - Same rule for S, independently.
  - With BYPASS=0, read ports always show stored contents.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr=1 at a clock edge; counter loads 0.
  - In CLEAR, each edge sets mem[cnt] <= 0, vld[cnt] <= 0, cnt <= cnt+1.
  - When cnt == 2^ADDR_W-1, that word is cleared and the FSM returns to IDLE; the counter wraps to 0.
  - busy = (state == CLEAR), registered, for exactly 2^ADDR_W cycles per request.
- Simultaneous events:
  - clr and we in the same IDLE cycle: the write commits at that edge; the clear starts at the same edge and will later zero that word.
  - clr while busy: ignored, no retrigger.
  - we while busy: write dropped, wr_drop = 1 that cycle, no bypass.
  - Reads during CLEAR return current contents; already-cleared words read 0 with vld 0.

Optional Feature:
- Macro: REG_FILE_P_R0_ZERO_EN.
- Defined:
  - word 0 is hardwired: reads return 0 with vld = 1.
  - Writes to address 0 are discarded without asserting wr_drop.
  - Bypass never applies to address 0.
  - The clear sequence still steps through address 0, taking 2^ADDR_W cycles.
- Undefined: word 0 is an ordinary register.

Decomposition:
- Shared package reg_file_pkg holds:
  - FSM state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1.
  - Default constants DATA_W_DEF=16, ADDR_W_DEF=3.
- One sub-module, clr_seq: the clear FSM plus ADDR_W-bit counter.
  - Inputs: clk, reset, clr.
  - Outputs: busy, clr_adr, clr_we.
- The top module holds the array, valid bits, read muxes and bypass logic.

Test Plan:
- Reset then read: after reset release, all 8 addresses read R=S=0x0000, R_vld=S_vld=0, busy=0.
- Write/read: we=1, W_Adr=5, W=0xBEEF. Next cycle R_Adr=5 gives R=0xBEEF, R_vld=1. S_Adr=4 gives S=0x0000, S_vld=0.
- Bypass: BYPASS=1, we=1, W_Adr=3, W=0x1234, R_Adr=S_Adr=3 in the same cycle -> R=S=0x1234 combinationally. With BYPASS=0 -> old value 0x0000.
- Clear sequence: fill all words with 0xA5A5, pulse clr for 1 cycle. Required: busy high exactly 8 cycles; word k reads 0 from cycle k+1 after the clr edge; we=1 during busy gives wr_drop=1 and memory unchanged.
- Reset mid-clear: pulse clr, assert reset low at busy cycle 3 -> busy=0 immediately, all words 0; after release a new clr runs the full 8 cycles.
- REG_FILE_P_R0_ZERO_EN defined: we=1, W_Adr=0, W=0xFFFF -> R_Adr=0 reads 0x0000 with R_vld=1, wr_drop=0.
